// File: rtl/lab1_imul_iter_ctrl_if.sv
// ----------------------------------------------------------------------------
// lab1_imul_iter_ctrl_if
//
// Request/response handshake bundle for the iterative multiplier control unit.
//
// Signals:
//   req_val  : request valid, driven by the upstream requester
//   req_rdy  : request ready, driven by the control unit
//   resp_val : response valid, driven by the control unit
//   resp_rdy : response ready, driven by the downstream consumer
//
// Modports:
//   master : the environment side (drives req_val and resp_rdy)
//   slave  : the control unit side (drives req_rdy and resp_val)
// ----------------------------------------------------------------------------
interface lab1_imul_iter_ctrl_if;
  logic req_val;
  logic req_rdy;
  logic resp_val;
  logic resp_rdy;

  modport master (
    output req_val,
    input  req_rdy,
    input  resp_val,
    output resp_rdy
  );

  modport slave (
    input  req_val,
    output req_rdy,
    output resp_val,
    input  resp_rdy
  );
endinterface

// File: rtl/lab1_imul_iter_ctrl.sv
// ----------------------------------------------------------------------------
// lab1_imul_iter_ctrl
//
// Control unit for a p_nbits-wide iterative shift-add multiplier. It accepts
// one request, then sequences the datapath through p_nbits shift-add
// iterations, then presents the result until the consumer takes it.
//
//   IDLE : load A, B from the request and clear the result register
//   CALC : shift A left, shift B right, add A into result when B[0] is set
//   DONE : hold the result and assert resp_val until resp_rdy
//
// Parameters:
//   p_nbits        : operand width and number of shift-add iterations
//
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous, active-high reset
//   hs             : request/response handshake (slave modport)
//   b_lsb          : bit 0 of the datapath B register
//   b_is_zero      : datapath B register equals zero
//   a_mux_sel      : 1 = load A from request, 0 = A << 1
//   b_mux_sel      : 1 = load B from request, 0 = B >> 1
//   result_mux_sel : 1 = result next is 0, 0 = result next is adder-mux output
//   add_mux_sel    : 1 = result + A, 0 = result unchanged
//   result_en      : result register write enable
//   iter_count     : completed iterations of the current operation
//
// Optional feature:
//   LAB1_IMUL_ITER_CTRL_EARLY_EXIT_EN : when defined, CALC finishes as soon as
//   the B register reaches zero, because no further partial products can be
//   added. Without it b_is_zero is ignored and CALC always runs p_nbits cycles.
// ----------------------------------------------------------------------------
module lab1_imul_iter_ctrl #(
  parameter  int unsigned p_nbits = 32,
  localparam int unsigned CNT_W   = $clog2(p_nbits + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  lab1_imul_iter_ctrl_if.slave     hs,
  input  logic                     b_lsb,
  input  logic                     b_is_zero,
  output logic                     a_mux_sel,
  output logic                     b_mux_sel,
  output logic                     result_mux_sel,
  output logic                     add_mux_sel,
  output logic                     result_en,
  output logic [CNT_W-1:0]         iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value seen during the final CALC cycle, and the saturation ceiling.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_nbits - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_nbits);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_next;

  // Increment that sticks at p_nbits so the count can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_FULL) begin
      return CNT_FULL;
    end
    return v + CNT_W'(1);
  endfunction

`ifdef LAB1_IMUL_ITER_CTRL_EARLY_EXIT_EN
  logic early_exit;
  assign early_exit = b_is_zero;
`else
  logic early_exit;
  logic b_is_zero_unused;
  assign early_exit       = 1'b0;
  assign b_is_zero_unused = b_is_zero;
`endif

  // State and iteration counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      iter_count <= '0;
    end else begin
      state      <= state_next;
      iter_count <= cnt_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next     = state;
    cnt_next       = iter_count;
    hs.req_rdy     = 1'b0;
    hs.resp_val    = 1'b0;
    a_mux_sel      = 1'b0;
    b_mux_sel      = 1'b0;
    result_mux_sel = 1'b0;
    add_mux_sel    = 1'b0;
    result_en      = 1'b0;

    unique case (state)
      IDLE: begin
        hs.req_rdy     = 1'b1;
        a_mux_sel      = 1'b1;
        b_mux_sel      = 1'b1;
        result_mux_sel = 1'b1;
        // Clear the result register in the same cycle the operands load.
        result_en      = hs.req_val;
        if (hs.req_val) begin
          state_next = CALC;
          cnt_next   = '0;
        end
      end

      CALC: begin
        result_en   = 1'b1;
        add_mux_sel = b_lsb;
        cnt_next    = sat_inc(iter_count);
        if (iter_count >= CNT_LAST) begin
          state_next = DONE;
        end
        // Once B is zero the result is final; freeze it and the count.
        if (early_exit) begin
          state_next = DONE;
          cnt_next   = iter_count;
          result_en  = 1'b0;
        end
      end

      DONE: begin
        hs.resp_val = 1'b1;
        if (hs.resp_rdy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // The register is already forced to IDLE by reset, but the IDLE decode
    // would otherwise advertise readiness and enable the result register.
    if (reset) begin
      hs.req_rdy  = 1'b0;
      hs.resp_val = 1'b0;
      result_en   = 1'b0;
    end
  end

endmodule
